// File: rtl/spi_master_xfer_if.sv
// Word handshake plus SPI pin bundle for spi_master_xfer.
// The master modport is the engine's view; slave is the view of whoever feeds it.
interface spi_master_xfer_if #(
    parameter int DATA_W = 8
);
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_last;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              busy;
    logic              SCLK;
    logic              MOSI;
    logic              MISO;
    logic              CS;

    modport master (
        input  tx_valid, tx_data, tx_last, MISO,
        output tx_ready, rx_valid, rx_data, busy, SCLK, MOSI, CS
    );

    modport slave (
        output tx_valid, tx_data, tx_last, MISO,
        input  tx_ready, rx_valid, rx_data, busy, SCLK, MOSI, CS
    );
endinterface

// File: rtl/spi_master_xfer.sv
// Full-duplex SPI master: shifts one word per handshake with configurable mode,
// bit order and SCLK rate, holding CS low across words until a word marked last.
module spi_master_xfer #(
    parameter int DATA_W        = 8,
    parameter int CLKS_PER_HALF = 25,
    parameter bit CPOL          = 1'b0,
    parameter bit CPHA          = 1'b0,
    parameter bit MSB_FIRST     = 1'b1
) (
    input logic               clk,
    input logic               rst,
    spi_master_xfer_if.master bus
);
    localparam int HCW = (CLKS_PER_HALF > 1) ? $clog2(CLKS_PER_HALF) : 1;
    localparam int ECW = $clog2(2 * DATA_W + 1);
    localparam logic [HCW-1:0] HALF_MAX   = HCW'(CLKS_PER_HALF - 1);
    localparam logic [ECW-1:0] FINAL_EDGE = ECW'(2 * DATA_W - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, TRAIL, GAP} xferState_e;

    xferState_e        state_q, state_d;
    logic [HCW-1:0]    halfCnt_q, halfCnt_d;
    logic [ECW-1:0]    edgeCnt_q, edgeCnt_d;
    logic [DATA_W-1:0] txShift_q, txShift_d;
    logic [DATA_W-1:0] rxShift_q, rxShift_d;
    logic [DATA_W-1:0] rxData_q, rxData_d;
    logic              last_q, last_d;
    logic              cs_q, cs_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              rxValid_q, rxValid_d;

    logic              handshake, halfDone, finalEdge, sampleEdge;
    logic              firstBit, headBit, nextBit;
    logic [DATA_W-1:0] txShifted, rxShifted;

    assign bus.tx_ready = (state_q == IDLE) || (state_q == HOLD);
    assign bus.busy     = (state_q != IDLE);
    assign bus.CS       = cs_q;
    assign bus.SCLK     = sclk_q;
    assign bus.MOSI     = mosi_q;
    assign bus.rx_valid = rxValid_q;
    assign bus.rx_data  = rxData_q;

    assign handshake = bus.tx_valid && bus.tx_ready;
    assign halfDone  = (halfCnt_q == HALF_MAX);
    assign finalEdge = (edgeCnt_q == FINAL_EDGE);
    // edgeCnt_q even means the upcoming SCLK edge is a leading (odd-numbered) one
    assign sampleEdge = CPHA ? edgeCnt_q[0] : ~edgeCnt_q[0];

    assign firstBit  = MSB_FIRST ? bus.tx_data[DATA_W-1] : bus.tx_data[0];
    assign headBit   = MSB_FIRST ? txShift_q[DATA_W-1] : txShift_q[0];
    assign nextBit   = MSB_FIRST ? txShift_q[DATA_W-2] : txShift_q[1];
    assign txShifted = MSB_FIRST ? {txShift_q[DATA_W-2:0], 1'b0} : {1'b0, txShift_q[DATA_W-1:1]};
    assign rxShifted = MSB_FIRST ? {rxShift_q[DATA_W-2:0], bus.MISO} : {bus.MISO, rxShift_q[DATA_W-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            halfCnt_q <= '0;
            edgeCnt_q <= '0;
            txShift_q <= '0;
            rxShift_q <= '0;
            rxData_q  <= '0;
            last_q    <= 1'b0;
            cs_q      <= 1'b1;
            sclk_q    <= CPOL;
            mosi_q    <= 1'b0;
            rxValid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            halfCnt_q <= halfCnt_d;
            edgeCnt_q <= edgeCnt_d;
            txShift_q <= txShift_d;
            rxShift_q <= rxShift_d;
            rxData_q  <= rxData_d;
            last_q    <= last_d;
            cs_q      <= cs_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            rxValid_q <= rxValid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        halfCnt_d = halfCnt_q;
        edgeCnt_d = edgeCnt_q;
        txShift_d = txShift_q;
        rxShift_d = rxShift_q;
        rxData_d  = rxData_q;
        last_d    = last_q;
        cs_d      = cs_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        rxValid_d = 1'b0;

        case (state_q)
            IDLE, HOLD: begin
                if (handshake) begin
                    state_d   = SETUP;
                    halfCnt_d = '0;
                    edgeCnt_d = '0;
                    txShift_d = bus.tx_data;
                    last_d    = bus.tx_last;
                    cs_d      = 1'b0;
                    sclk_d    = CPOL;
                    mosi_d    = firstBit;
                end
            end
            SETUP: begin
                halfCnt_d = halfDone ? '0 : halfCnt_q + 1'b1;
                if (halfDone) state_d = SHIFT;
            end
            SHIFT: begin
                halfCnt_d = halfDone ? '0 : halfCnt_q + 1'b1;
                if (halfDone) begin
                    sclk_d    = ~sclk_q;
                    edgeCnt_d = edgeCnt_q + 1'b1;
                    if (sampleEdge) begin
                        rxShift_d = rxShifted;
                    end else if (CPHA && (edgeCnt_q == '0)) begin
                        mosi_d = headBit;
                    end else if (!finalEdge) begin
                        txShift_d = txShifted;
                        mosi_d    = nextBit;
                    end
                    // With CPHA=1 the final edge is also the last sample, so take it directly
                    if (finalEdge) begin
                        rxValid_d = 1'b1;
                        rxData_d  = CPHA ? rxShifted : rxShift_q;
                        sclk_d    = CPOL;
                        edgeCnt_d = '0;
                        state_d   = last_q ? TRAIL : HOLD;
                    end
                end
            end
            TRAIL: begin
                halfCnt_d = halfDone ? '0 : halfCnt_q + 1'b1;
                if (halfDone) begin
                    cs_d    = 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                halfCnt_d = halfDone ? '0 : halfCnt_q + 1'b1;
                if (halfDone) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_spi_master_xfer.sv
// Directed bench for spi_master_xfer: four instances cover modes 0/1/3,
// LSB-first 16-bit words, bursts, mid-word reset and ignored tx_valid during SHIFT.
module tb_spi_master_xfer;
    logic clk;
    logic rst;
    int   cyc = 0;
    int   vecCnt = 0;
    int   failCnt = 0;

    spi_master_xfer_if #(.DATA_W(8))  if0 ();
    spi_master_xfer_if #(.DATA_W(8))  if3 ();
    spi_master_xfer_if #(.DATA_W(8))  if1 ();
    spi_master_xfer_if #(.DATA_W(16)) if16 ();

    spi_master_xfer #(.DATA_W(8), .CLKS_PER_HALF(2), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1))
        u0 (.clk(clk), .rst(rst), .bus(if0));
    spi_master_xfer #(.DATA_W(8), .CLKS_PER_HALF(2), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1))
        u3 (.clk(clk), .rst(rst), .bus(if3));
    spi_master_xfer #(.DATA_W(8), .CLKS_PER_HALF(2), .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b1))
        u1 (.clk(clk), .rst(rst), .bus(if1));
    spi_master_xfer #(.DATA_W(16), .CLKS_PER_HALF(2), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b0))
        u16 (.clk(clk), .rst(rst), .bus(if16));

    assign if0.MISO  = if0.MOSI;
    assign if1.MISO  = if1.MOSI;
    assign if16.MISO = if16.MOSI;

    // Mode-3 slave: drives on falling (leading) SCLK, captures on rising (trailing) SCLK
    logic [7:0]  slaveTx = 8'h3C;
    logic [7:0]  slaveRx = 8'h00;
    logic        miso3 = 1'b0;
    int          sIdx = 0;
    logic [15:0] mosiSeq = 16'h0000;

    assign if3.MISO = miso3;

    always @(negedge if3.SCLK or posedge if3.CS) begin
        if (if3.CS) begin
            sIdx <= 0;
        end else begin
            miso3 <= slaveTx[7-sIdx];
            sIdx  <= sIdx + 1;
        end
    end

    always @(posedge if3.SCLK) begin
        if (if3.CS === 1'b0) slaveRx <= {slaveRx[6:0], if3.MOSI};
    end

    always @(posedge if16.SCLK) begin
        if (if16.CS === 1'b0) mosiSeq <= {mosiSeq[14:0], if16.MOSI};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event counters, sampled just after the falling edge once the stimulus has settled
    int   tog0 = 0, tog3 = 0, rxp0 = 0, rxp3 = 0, rxp1 = 0, csr0 = 0, csr1 = 0, hs1 = 0, rdyBusy1 = 0;
    logic sclkPrev0 = 1'b0, sclkPrev3 = 1'b1, csPrev0 = 1'b1, csPrev1 = 1'b1;

    always begin
        @(negedge clk);
        #1;
        if (if0.SCLK !== sclkPrev0) tog0++;
        if (if3.SCLK !== sclkPrev3) tog3++;
        if (if0.rx_valid === 1'b1) rxp0++;
        if (if3.rx_valid === 1'b1) rxp3++;
        if (if1.rx_valid === 1'b1) rxp1++;
        if (if0.CS === 1'b1 && csPrev0 === 1'b0) csr0++;
        if (if1.CS === 1'b1 && csPrev1 === 1'b0) csr1++;
        if (if1.tx_valid === 1'b1 && if1.tx_ready === 1'b1) hs1++;
        if (if1.tx_ready === 1'b1 && if1.busy === 1'b1) rdyBusy1++;
        sclkPrev0 = if0.SCLK;
        sclkPrev3 = if3.SCLK;
        csPrev0   = if0.CS;
        csPrev1   = if1.CS;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("[TB] FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic waitUntil(input int base, input int rel);
        while (cyc < base + rel) @(negedge clk);
    endtask

    int b, s0, s1, s2, s3, s4;

    initial begin
        rst = 1'b1;
        if0.tx_valid = 1'b0;  if0.tx_data = '0;  if0.tx_last = 1'b0;
        if3.tx_valid = 1'b0;  if3.tx_data = '0;  if3.tx_last = 1'b0;
        if1.tx_valid = 1'b0;  if1.tx_data = '0;  if1.tx_last = 1'b0;
        if16.tx_valid = 1'b0; if16.tx_data = '0; if16.tx_last = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("rst_cs",       if0.CS, 1'b1);
        checkOutput("rst_sclk0",    if0.SCLK, 1'b0);
        checkOutput("rst_sclk3",    if3.SCLK, 1'b1);
        checkOutput("rst_mosi",     if0.MOSI, 1'b0);
        checkOutput("rst_rx_valid", if0.rx_valid, 1'b0);
        checkOutput("rst_rx_data",  if0.rx_data, 8'h00);
        checkOutput("rst_busy",     if0.busy, 1'b0);
        checkOutput("rst_tx_ready", if0.tx_ready, 1'b1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Mode 0 loopback, single word 0xA5
        b = cyc; s0 = tog0; s1 = rxp0; s2 = csr0;
        if0.tx_valid = 1'b1; if0.tx_data = 8'hA5; if0.tx_last = 1'b1;
        waitUntil(b, 1);
        if0.tx_valid = 1'b0;
        checkOutput("m0_cs_fall",   if0.CS, 1'b0);
        checkOutput("m0_ready_lo",  if0.tx_ready, 1'b0);
        checkOutput("m0_busy",      if0.busy, 1'b1);
        checkOutput("m0_first_bit", if0.MOSI, 1'b1);
        waitUntil(b, 4);  checkOutput("m0_sclk_pre",  if0.SCLK, 1'b0);
        waitUntil(b, 5);  checkOutput("m0_sclk_e1",   if0.SCLK, 1'b1);
        waitUntil(b, 34); checkOutput("m0_rxv_early", if0.rx_valid, 1'b0);
        checkOutput("m0_sclk_e15", if0.SCLK, 1'b1);
        waitUntil(b, 35);
        checkOutput("m0_rxv",       if0.rx_valid, 1'b1);
        checkOutput("m0_rx_data",   if0.rx_data, 8'hA5);
        checkOutput("m0_sclk_idle", if0.SCLK, 1'b0);
        waitUntil(b, 36);
        checkOutput("m0_rxv_pulse", if0.rx_valid, 1'b0);
        checkOutput("m0_cs_trail",  if0.CS, 1'b0);
        waitUntil(b, 37); checkOutput("m0_cs_rise",  if0.CS, 1'b1);
        waitUntil(b, 38); checkOutput("m0_gap_rdy",  if0.tx_ready, 1'b0);
        waitUntil(b, 39);
        checkOutput("m0_idle_rdy",  if0.tx_ready, 1'b1);
        checkOutput("m0_idle_busy", if0.busy, 1'b0);
        checkOutput("m0_toggles",   tog0 - s0, 16);
        checkOutput("m0_rx_pulses", rxp0 - s1, 1);
        checkOutput("m0_cs_rises",  csr0 - s2, 1);

        // Mode 3 against the slave model
        repeat (2) @(negedge clk);
        b = cyc; s0 = tog3; s1 = rxp3;
        checkOutput("m3_sclk_idle", if3.SCLK, 1'b1);
        if3.tx_valid = 1'b1; if3.tx_data = 8'hC3; if3.tx_last = 1'b1;
        waitUntil(b, 1);
        if3.tx_valid = 1'b0;
        waitUntil(b, 5);  checkOutput("m3_sclk_e1", if3.SCLK, 1'b0);
        waitUntil(b, 35);
        checkOutput("m3_rxv",      if3.rx_valid, 1'b1);
        checkOutput("m3_rx_data",  if3.rx_data, 8'h3C);
        checkOutput("m3_sclk_end", if3.SCLK, 1'b1);
        waitUntil(b, 39);
        checkOutput("m3_idle_rdy", if3.tx_ready, 1'b1);
        checkOutput("m3_slave_rx", slaveRx, 8'hC3);
        checkOutput("m3_toggles",  tog3 - s0, 16);
        checkOutput("m3_rx_pulses", rxp3 - s1, 1);

        // Mode 1 burst 0x01, 0x80, 0xFF; tx_data changes during SHIFT must be ignored
        repeat (2) @(negedge clk);
        b = cyc; s0 = rxp1; s1 = csr1; s2 = hs1; s3 = rdyBusy1;
        if1.tx_valid = 1'b1; if1.tx_data = 8'h01; if1.tx_last = 1'b0;
        waitUntil(b, 1);
        if1.tx_data = 8'h80;
        checkOutput("b_ready_lo", if1.tx_ready, 1'b0);
        waitUntil(b, 20);
        checkOutput("b_mid_ready", if1.tx_ready, 1'b0);
        checkOutput("b_mid_cs",    if1.CS, 1'b0);
        waitUntil(b, 35);
        checkOutput("b_w1_rxv",   if1.rx_valid, 1'b1);
        checkOutput("b_w1_data",  if1.rx_data, 8'h01);
        checkOutput("b_hold_rdy", if1.tx_ready, 1'b1);
        checkOutput("b_hold_cs",  if1.CS, 1'b0);
        checkOutput("b_hold_sclk", if1.SCLK, 1'b0);
        waitUntil(b, 36);
        checkOutput("b_w2_rdy", if1.tx_ready, 1'b0);
        if1.tx_data = 8'hFF; if1.tx_last = 1'b1;
        waitUntil(b, 40); checkOutput("b_w2_e1", if1.SCLK, 1'b1);
        waitUntil(b, 70);
        checkOutput("b_w2_rxv",  if1.rx_valid, 1'b1);
        checkOutput("b_w2_data", if1.rx_data, 8'h80);
        checkOutput("b_w2_cs",   if1.CS, 1'b0);
        waitUntil(b, 71);
        if1.tx_valid = 1'b0;
        waitUntil(b, 105);
        checkOutput("b_w3_rxv",   if1.rx_valid, 1'b1);
        checkOutput("b_w3_data",  if1.rx_data, 8'hFF);
        checkOutput("b_trail_rdy", if1.tx_ready, 1'b0);
        waitUntil(b, 107); checkOutput("b_cs_rise", if1.CS, 1'b1);
        waitUntil(b, 109); checkOutput("b_idle_rdy", if1.tx_ready, 1'b1);
        waitUntil(b, 110);
        checkOutput("b_rx_pulses",  rxp1 - s0, 3);
        checkOutput("b_cs_rises",   csr1 - s1, 1);
        checkOutput("b_handshakes", hs1 - s2, 3);
        checkOutput("b_hold_cycles", rdyBusy1 - s3, 2);

        // 16-bit LSB-first loopback
        repeat (2) @(negedge clk);
        b = cyc;
        if16.tx_valid = 1'b1; if16.tx_data = 16'h1234; if16.tx_last = 1'b1;
        waitUntil(b, 1);
        if16.tx_valid = 1'b0;
        checkOutput("l_first_bit", if16.MOSI, 1'b0);
        waitUntil(b, 67);
        checkOutput("l_rxv",     if16.rx_valid, 1'b1);
        checkOutput("l_rx_data", if16.rx_data, 16'h1234);
        waitUntil(b, 71);
        checkOutput("l_idle_rdy", if16.tx_ready, 1'b1);
        checkOutput("l_mosi_seq", mosiSeq, 16'h2C48);

        // Reset at SCLK edge 7 of a mode-0 word, then a fresh word
        repeat (2) @(negedge clk);
        b = cyc; s4 = rxp0;
        checkOutput("r_rx_hold", if0.rx_data, 8'hA5);
        if0.tx_valid = 1'b1; if0.tx_data = 8'h33; if0.tx_last = 1'b1;
        waitUntil(b, 1);
        if0.tx_valid = 1'b0;
        waitUntil(b, 17);
        checkOutput("r_sclk_e7", if0.SCLK, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("r_cs",      if0.CS, 1'b1);
        checkOutput("r_sclk",    if0.SCLK, 1'b0);
        checkOutput("r_mosi",    if0.MOSI, 1'b0);
        checkOutput("r_busy",    if0.busy, 1'b0);
        checkOutput("r_ready",   if0.tx_ready, 1'b1);
        checkOutput("r_rx_data", if0.rx_data, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("r_no_rxv", rxp0 - s4, 0);
        b = cyc;
        if0.tx_valid = 1'b1; if0.tx_data = 8'h5A; if0.tx_last = 1'b1;
        waitUntil(b, 1);
        if0.tx_valid = 1'b0;
        checkOutput("r2_cs_fall", if0.CS, 1'b0);
        waitUntil(b, 35);
        checkOutput("r2_rxv",     if0.rx_valid, 1'b1);
        checkOutput("r2_rx_data", if0.rx_data, 8'h5A);
        waitUntil(b, 39);
        checkOutput("r2_idle_rdy", if0.tx_ready, 1'b1);
        checkOutput("r2_rx_pulses", rxp0 - s4, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, failCnt);
        $finish;
    end
endmodule
